// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Package : seg7_pkg
//  Shared types and helpers for the multiplexed 7-segment scan driver.
//  Revision: 1.0
// ============================================================================
package seg7_pkg;

   localparam int NUM_DIGITS = 4;
   localparam int SEG_W      = 7;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      ON    = 2'd2
   } seg7_state_t;

   // Digit k occupies frame[7k+6:7k], bit 0 of each field is segment a.
   function automatic logic [SEG_W-1:0] seg_field(
      input logic [NUM_DIGITS*SEG_W-1:0] frame,
      input logic [1:0]                  idx
   );
      return frame[int'(idx)*SEG_W +: SEG_W];
   endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module  : seg7_scan_driver
//  Time-multiplexed 4-digit 7-segment driver with per-slot blanking and a
//  frame buffer that is reloaded only at frame boundaries.
//  Revision: 1.0
// ============================================================================
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int DIGIT_CYCLES   = 50000,
   parameter int BLANK_CYCLES   = 500,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit DIG_ACTIVE_LOW = 1'b1
)(
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        enable,
   input  logic [NUM_DIGITS*SEG_W-1:0] seg_in,
   output logic [SEG_W-1:0]            seg_out,
   output logic [NUM_DIGITS-1:0]       dig_out,
   output logic                        frame_start
);

   localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(DIGIT_CYCLES - 1);
   localparam logic [1:0]       LAST_DIGIT = 2'(NUM_DIGITS - 1);

   if ((BLANK_CYCLES < 1) || (DIGIT_CYCLES <= BLANK_CYCLES)) begin : g_param_check
      $error("seg7_scan_driver: need BLANK_CYCLES>=1 and DIGIT_CYCLES>BLANK_CYCLES");
   end

   seg7_state_t                  r_state, w_state_nx;
   logic [1:0]                   r_idx, w_idx_nx;
   logic [CNT_W-1:0]             r_cnt, w_cnt_nx;
   logic [NUM_DIGITS*SEG_W-1:0]  r_frame;
   logic                         w_load;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nx;
         r_idx   <= w_idx_nx;
         r_cnt   <= w_cnt_nx;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_frame <= '0;
      end else if (w_load) begin
         r_frame <= seg_in;
      end
   end

   // The counter runs across the whole slot; BLANK covers its first BLANK_CYCLES values.
   always_comb begin
      w_state_nx = r_state;
      w_idx_nx   = r_idx;
      w_cnt_nx   = r_cnt;
      w_load     = 1'b0;
      if (!enable) begin
         w_state_nx = IDLE;
         w_idx_nx   = '0;
         w_cnt_nx   = '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               w_state_nx = BLANK;
               w_idx_nx   = '0;
               w_cnt_nx   = '0;
               w_load     = 1'b1;
            end
            BLANK: begin
               w_cnt_nx = r_cnt + CNT_W'(1);
               if (r_cnt == BLANK_LAST) begin
                  w_state_nx = ON;
               end
            end
            ON: begin
               if (r_cnt == SLOT_LAST) begin
                  w_state_nx = BLANK;
                  w_cnt_nx   = '0;
                  w_idx_nx   = r_idx + 2'd1;
                  w_load     = (r_idx == LAST_DIGIT);
               end else begin
                  w_cnt_nx = r_cnt + CNT_W'(1);
               end
            end
            default: begin
               w_state_nx = IDLE;
               w_idx_nx   = '0;
               w_cnt_nx   = '0;
            end
         endcase
      end
   end

   logic                  w_on;
   logic [SEG_W-1:0]      w_seg_lit;
   logic [NUM_DIGITS-1:0] w_dig_lit;

   always_comb begin
      w_on      = (r_state == ON);
      w_seg_lit = w_on ? seg_field(r_frame, r_idx) : '0;
      w_dig_lit = w_on ? (NUM_DIGITS'(1) << r_idx) : '0;
      seg_out   = SEG_ACTIVE_LOW ? ~w_seg_lit : w_seg_lit;
      dig_out   = DIG_ACTIVE_LOW ? ~w_dig_lit : w_dig_lit;
      frame_start = (r_state == BLANK) && (r_idx == 2'd0) && (r_cnt == '0);
   end

endmodule
`default_nettype wire
